// File: rtl/reset_sequencer_pkg.sv
// ============================================================================
// Module   : reset_sequencer_pkg
// Brief    : State encodings and elaboration helpers for the reset sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package reset_sequencer_pkg;

    localparam logic [1:0] C_ST_HOLD    = 2'd0;
    localparam logic [1:0] C_ST_RELEASE = 2'd1;
    localparam logic [1:0] C_ST_RUN     = 2'd2;

    typedef enum logic [1:0] {
        ST_HOLD    = C_ST_HOLD,
        ST_RELEASE = C_ST_RELEASE,
        ST_RUN     = C_ST_RUN
    } seq_state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic bit params_ok(input int nstages, input int sync_depth,
                                     input int hold_cycles, input int gap_cycles);
        return (nstages >= 1) && (sync_depth >= 2) &&
               (hold_cycles >= 1) && (gap_cycles >= 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/reset_sequencer_sync.sv
// ============================================================================
// Module   : reset_sequencer_sync
// Brief    : Multi-flop synchroniser for the PLL lock input, cleared by clr.
// Revision : 1.0
// ============================================================================
`default_nettype none

module reset_sequencer_sync #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] r_chain;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[DEPTH-2:0], d};
        end
    end

    assign q = r_chain[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/reset_sequencer.sv
// ============================================================================
// Module   : reset_sequencer
// Brief    : Staged reset release after stable PLL lock; async assert on clr,
//            synchronous in-order deassert, abort on lock loss or sw_rst.
// Revision : 1.0
// ============================================================================
`default_nettype none

module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int NSTAGES     = 4,
    parameter int SYNC_DEPTH  = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 4
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               lock,
    input  logic               sw_rst,
    output logic [NSTAGES-1:0] rst_out,
    output logic               busy,
    output logic               ready
);

    localparam int CW = $clog2(max2(HOLD_CYCLES, GAP_CYCLES) + 1);
    localparam int KW = $clog2(NSTAGES) + 1;

    localparam logic [CW-1:0] C_HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] C_GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [KW-1:0] C_K_LAST    = KW'(NSTAGES - 1);

    if (!params_ok(NSTAGES, SYNC_DEPTH, HOLD_CYCLES, GAP_CYCLES)) begin : g_param_check
        $error("reset_sequencer: illegal parameter combination");
    end

    logic               w_lock_s;
    logic               w_abort;
    seq_state_t         r_state;
    seq_state_t         w_state_nxt;
    logic [CW-1:0]      r_cnt;
    logic [CW-1:0]      w_cnt_nxt;
    logic [KW-1:0]      r_k;
    logic [KW-1:0]      w_k_nxt;
    logic [KW-1:0]      w_k_inc;
    logic [NSTAGES-1:0] w_clr_mask;
    logic               r_busy;
    logic               r_ready;

    reset_sequencer_sync #(
        .DEPTH (SYNC_DEPTH)
    ) u_lock_sync (
        .clk (clk),
        .clr (clr),
        .d   (lock),
        .q   (w_lock_s)
    );

    // Lock loss and soft reset collapse into one abort that outranks any release.
    assign w_abort = ~w_lock_s | sw_rst;
    assign w_k_inc = r_k + KW'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_k_nxt     = r_k;
        w_clr_mask  = '0;
        if (w_abort) begin
            w_state_nxt = ST_HOLD;
            w_cnt_nxt   = '0;
            w_k_nxt     = '0;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    if (r_cnt == C_HOLD_LAST) begin
                        w_clr_mask[0] = 1'b1;
                        w_cnt_nxt     = '0;
                        w_k_nxt       = '0;
                        w_state_nxt   = (NSTAGES == 1) ? ST_RUN : ST_RELEASE;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
                ST_RELEASE: begin
                    if (r_cnt == C_GAP_LAST) begin
                        for (int i = 1; i < NSTAGES; i++) begin
                            if (w_k_inc == KW'(i)) begin
                                w_clr_mask[i] = 1'b1;
                            end
                        end
                        w_k_nxt   = w_k_inc;
                        w_cnt_nxt = '0;
                        if (w_k_inc == C_K_LAST) begin
                            w_state_nxt = ST_RUN;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
                ST_RUN: begin
                    w_state_nxt = ST_RUN;
                end
                default: begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = '0;
                    w_k_nxt     = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= ST_HOLD;
            r_cnt   <= '0;
            r_k     <= '0;
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_k     <= w_k_nxt;
            r_busy  <= (w_state_nxt != ST_RUN);
            r_ready <= (w_state_nxt == ST_RUN);
        end
    end

    // One async-set flop per stage: set by clr or abort, cleared by its release strobe.
    for (genvar gi = 0; gi < NSTAGES; gi++) begin : g_stage
        logic r_q;
        always_ff @(posedge clk or posedge clr) begin
            if (clr) begin
                r_q <= 1'b1;
            end else if (w_abort) begin
                r_q <= 1'b1;
            end else if (w_clr_mask[gi]) begin
                r_q <= 1'b0;
            end
        end
        assign rst_out[gi] = r_q;
    end

    assign busy  = r_busy;
    assign ready = r_ready;

endmodule

`default_nettype wire

// File: tb/tb_reset_sequencer.sv
// ============================================================================
// Module   : tb_reset_sequencer
// Brief    : Self-checking bench: default instance plus a 1-stage/1-cycle one.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_reset_sequencer;

    logic       clk;
    logic       clr;
    logic       lock;
    logic       sw_rst;
    logic [3:0] rst_out;
    logic       busy;
    logic       ready;
    logic [0:0] rst2;
    logic       busy2;
    logic       ready2;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    reset_sequencer #(
        .NSTAGES(4), .SYNC_DEPTH(2), .HOLD_CYCLES(16), .GAP_CYCLES(4)
    ) u_dut (
        .clk(clk), .clr(clr), .lock(lock), .sw_rst(sw_rst),
        .rst_out(rst_out), .busy(busy), .ready(ready)
    );

    reset_sequencer #(
        .NSTAGES(1), .SYNC_DEPTH(2), .HOLD_CYCLES(1), .GAP_CYCLES(1)
    ) u_dut_small (
        .clk(clk), .clr(clr), .lock(lock), .sw_rst(sw_rst),
        .rst_out(rst2), .busy(busy2), .ready(ready2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         scen;
        bit         sel;     // 0: default instance, 1: small instance
        int         edge_n;  // edge number relative to scenario base
        logic [3:0] rst;
        logic       busy;
        logic       ready;
    } vec_t;

    typedef struct {
        int         cyc;
        bit         sel;
        logic [3:0] rst;
        logic       busy;
        logic       ready;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    function automatic vec_t mk(int s, bit sel, int e, logic [3:0] r, logic b, logic rd);
        vec_t v;
        v.scen = s; v.sel = sel; v.edge_n = e; v.rst = r; v.busy = b; v.ready = rd;
        return v;
    endfunction

    task automatic chk(input string nm, input int c, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, c, act, exp);
        end
    endtask

    task automatic load(input int s, input int base);
        foreach (tbl[i]) begin
            if (tbl[i].scen == s) begin
                exp_t e;
                e.cyc = base + tbl[i].edge_n; e.sel = tbl[i].sel;
                e.rst = tbl[i].rst; e.busy = tbl[i].busy; e.ready = tbl[i].ready;
                sb.push_back(e);
            end
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Scoreboard consumer: compares every expectation due at the current edge.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc < cyc) begin
                chk("missed_expectation", sb[i].cyc, 4'h1, 4'h0);
                sb.delete(i);
            end else if (sb[i].cyc == cyc) begin
                if (sb[i].sel == 1'b0) begin
                    chk("rst_out", cyc, rst_out, sb[i].rst);
                    chk("busy", cyc, {3'b0, busy}, {3'b0, sb[i].busy});
                    chk("ready", cyc, {3'b0, ready}, {3'b0, sb[i].ready});
                end else begin
                    chk("small_rst_out", cyc, {3'b0, rst2}, sb[i].rst);
                    chk("small_busy", cyc, {3'b0, busy2}, {3'b0, sb[i].busy});
                    chk("small_ready", cyc, {3'b0, ready2}, {3'b0, sb[i].ready});
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base1, base2, base3, base4;

        // Power-on sequence, lock already high
        tbl.push_back(mk(1, 0,  1, 4'hF, 1, 0));
        tbl.push_back(mk(1, 0, 17, 4'hF, 1, 0));
        tbl.push_back(mk(1, 0, 18, 4'hE, 1, 0));
        tbl.push_back(mk(1, 0, 21, 4'hE, 1, 0));
        tbl.push_back(mk(1, 0, 22, 4'hC, 1, 0));
        tbl.push_back(mk(1, 0, 25, 4'hC, 1, 0));
        tbl.push_back(mk(1, 0, 26, 4'h8, 1, 0));
        tbl.push_back(mk(1, 0, 29, 4'h8, 1, 0));
        tbl.push_back(mk(1, 0, 30, 4'h0, 0, 1));
        tbl.push_back(mk(1, 0, 31, 4'h0, 0, 1));
        tbl.push_back(mk(1, 1,  2, 4'h1, 1, 0));
        tbl.push_back(mk(1, 1,  3, 4'h0, 0, 1));
        // Lock arrives late (high after edge 10)
        tbl.push_back(mk(2, 0, 10, 4'hF, 1, 0));
        tbl.push_back(mk(2, 0, 27, 4'hF, 1, 0));
        tbl.push_back(mk(2, 0, 28, 4'hE, 1, 0));
        tbl.push_back(mk(2, 0, 32, 4'hC, 1, 0));
        tbl.push_back(mk(2, 0, 36, 4'h8, 1, 0));
        tbl.push_back(mk(2, 0, 39, 4'h8, 1, 0));
        tbl.push_back(mk(2, 0, 40, 4'h0, 0, 1));
        tbl.push_back(mk(2, 1, 12, 4'h1, 1, 0));
        tbl.push_back(mk(2, 1, 13, 4'h0, 0, 1));
        // Lock loss mid-release, regain, sw_rst in RUN, clr pulse mid-HOLD
        tbl.push_back(mk(3, 0, 22, 4'hC, 1, 0));
        tbl.push_back(mk(3, 0, 26, 4'h8, 1, 0));
        tbl.push_back(mk(3, 0, 27, 4'hF, 1, 0));
        tbl.push_back(mk(3, 0, 30, 4'hF, 1, 0));
        tbl.push_back(mk(3, 0, 47, 4'hF, 1, 0));
        tbl.push_back(mk(3, 0, 48, 4'hE, 1, 0));
        tbl.push_back(mk(3, 0, 60, 4'h0, 0, 1));
        tbl.push_back(mk(3, 0, 62, 4'h0, 0, 1));
        tbl.push_back(mk(3, 0, 63, 4'hF, 1, 0));
        tbl.push_back(mk(3, 0, 78, 4'hF, 1, 0));
        tbl.push_back(mk(3, 0, 79, 4'hF, 1, 0));
        tbl.push_back(mk(3, 0, 87, 4'hF, 1, 0));
        tbl.push_back(mk(3, 0, 88, 4'hE, 1, 0));
        tbl.push_back(mk(3, 0,100, 4'h0, 0, 1));
        tbl.push_back(mk(3, 1,  3, 4'h0, 0, 1));
        tbl.push_back(mk(3, 1, 27, 4'h1, 1, 0));
        tbl.push_back(mk(3, 1, 32, 4'h1, 1, 0));
        tbl.push_back(mk(3, 1, 33, 4'h0, 0, 1));
        tbl.push_back(mk(3, 1, 63, 4'h1, 1, 0));
        tbl.push_back(mk(3, 1, 64, 4'h0, 0, 1));
        tbl.push_back(mk(3, 1, 72, 4'h1, 1, 0));
        tbl.push_back(mk(3, 1, 73, 4'h0, 0, 1));
        // sw_rst on the edge where rst_out[0] is due
        tbl.push_back(mk(4, 0, 17, 4'hF, 1, 0));
        tbl.push_back(mk(4, 0, 18, 4'hF, 1, 0));
        tbl.push_back(mk(4, 0, 33, 4'hF, 1, 0));
        tbl.push_back(mk(4, 0, 34, 4'hE, 1, 0));
        tbl.push_back(mk(4, 1,  3, 4'h0, 0, 1));
        tbl.push_back(mk(4, 1, 18, 4'h1, 1, 0));
        tbl.push_back(mk(4, 1, 19, 4'h0, 0, 1));

        clr = 1'b1; lock = 1'b1; sw_rst = 1'b0;
        #1;
        chk("async_reset_rst_out", 0, rst_out, 4'hF);
        chk("async_reset_small", 0, {3'b0, rst2}, 4'h1);
        wait_cyc(2);
        chk("reset_busy", cyc, {3'b0, busy}, 4'h1);
        chk("reset_ready", cyc, {3'b0, ready}, 4'h0);

        // Scenario 1: power-on
        clr = 1'b0; base1 = cyc; load(1, base1);
        wait_cyc(base1 + 32);

        // Scenario 2: lock late
        clr = 1'b1; lock = 1'b0;
        @(negedge clk);
        clr = 1'b0; base2 = cyc; load(2, base2);
        wait_cyc(base2 + 10);
        lock = 1'b1;
        wait_cyc(base2 + 41);

        // Scenario 3: lock loss mid-release, sw_rst pulse, clr mid-HOLD
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0; base3 = cyc; load(3, base3);
        wait_cyc(base3 + 24);
        lock = 1'b0;
        wait_cyc(base3 + 30);
        lock = 1'b1;
        wait_cyc(base3 + 62);
        sw_rst = 1'b1;
        wait_cyc(base3 + 63);
        sw_rst = 1'b0;
        wait_cyc(base3 + 70);
        clr = 1'b1;
        #1;
        chk("clr_mid_hold_rst_out", cyc, rst_out, 4'hF);
        chk("clr_mid_hold_busy", cyc, {3'b0, busy}, 4'h1);
        #1;
        clr = 1'b0;
        wait_cyc(base3 + 102);
        chk("run_before_clr", cyc, {3'b0, ready}, 4'h1);
        clr = 1'b1;
        #1;
        chk("async_clr_rst_out", cyc, rst_out, 4'hF);
        chk("async_clr_ready", cyc, {3'b0, ready}, 4'h0);
        chk("async_clr_busy", cyc, {3'b0, busy}, 4'h1);
        chk("async_clr_small", cyc, {2'b0, rst2, ready2}, 4'h2);
        @(negedge clk);

        // Scenario 4: abort beats a release due on the same edge
        clr = 1'b0; base4 = cyc; load(4, base4);
        wait_cyc(base4 + 17);
        sw_rst = 1'b1;
        wait_cyc(base4 + 18);
        sw_rst = 1'b0;
        wait_cyc(base4 + 36);

        if (sb.size() != 0) begin
            total++; bad++;
            $display("FAIL scoreboard_drain: %0d left expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
